// File: rtl/sim_run_controller.sv
// Run sequencer for the simulation top. It holds the design under test in reset,
// counts run cycles, drains on a finish request or watchdog, then raises a sticky finish.
// Latency: finish_req at edge N gives DRAIN after edge N. With quiesced held high, finish rises after edge N+QUIESCE_CYCLES.
// Backpressure: none. Inputs are sampled every cycle, and a started drain cannot be cancelled.
//
// Ports:
//   CLK, RST_N   single clock; synchronous active-low reset
//   finish_req   level request to stop (ignored in HOLD)
//   quiesced     design reports no outstanding transactions
//   dut_rst_n    registered active-low reset to the design
//   cycle_count  cycles since reset release (frozen in DONE)
//   state        0=HOLD 1=RUN 2=DRAIN 3=DONE
//   finish       sticky, high in DONE
//   timed_out    sticky, DONE reached via drain timeout or run watchdog
//   heartbeat    one-cycle pulse every HEARTBEAT_PERIOD cycles (only with SIM_HEARTBEAT_EN)
//
// Optional feature macro: SIM_HEARTBEAT_EN. Without it, heartbeat is tied low.
module sim_run_controller #(
    parameter int unsigned RESET_CYCLES     = 20,
    parameter int unsigned QUIESCE_CYCLES   = 4,
    parameter int unsigned DRAIN_TIMEOUT    = 1000,
    parameter int unsigned MAX_CYCLES       = 0,
    parameter int unsigned HEARTBEAT_PERIOD = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        finish_req,
    input  logic        quiesced,
    output logic        dut_rst_n,
    output logic [31:0] cycle_count,
    output logic [1:0]  state,
    output logic        finish,
    output logic        timed_out,
    output logic        heartbeat
);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] HOLD_LAST    = 16'(RESET_CYCLES - 1);
    localparam logic [7:0]  QUIESCE_LAST = 8'(QUIESCE_CYCLES - 1);
    localparam logic [31:0] DRAIN_LAST   = 32'(DRAIN_TIMEOUT - 1);
    localparam logic [31:0] MAX_LAST     = 32'(MAX_CYCLES - 1);
    localparam bit          TIMEOUT_EN   = (DRAIN_TIMEOUT != 0);
    localparam bit          WATCHDOG_EN  = (MAX_CYCLES != 0);

    // Reject parameter values outside the legal ranges at elaboration.
    if (RESET_CYCLES < 1 || RESET_CYCLES > 65535) begin : g_bad_reset_cycles
        $error("RESET_CYCLES out of range 1..65535");
    end
    if (QUIESCE_CYCLES < 1 || QUIESCE_CYCLES > 255) begin : g_bad_quiesce_cycles
        $error("QUIESCE_CYCLES out of range 1..255");
    end
    if (HEARTBEAT_PERIOD < 1) begin : g_bad_heartbeat_period
        $error("HEARTBEAT_PERIOD must be at least 1");
    end

    state_t      cur_state;
    logic [15:0] hold_cnt;
    logic [7:0]  quiesce_cnt;
    logic [31:0] drain_cnt;

    logic quiesce_done;
    logic drain_expired;
    logic watchdog_hit;
    logic hold_done;
    logic cnt_advance;

    assign hold_done     = (hold_cnt == HOLD_LAST);
    assign quiesce_done  = quiesced && (quiesce_cnt == QUIESCE_LAST);
    assign drain_expired = TIMEOUT_EN && (drain_cnt == DRAIN_LAST);
    assign watchdog_hit  = WATCHDOG_EN && (cycle_count == MAX_LAST);
    // The run counter moves in RUN and DRAIN, except on the edge that enters DONE.
    // That edge leaves the value frozen at the count of the final drain cycle.
    assign cnt_advance   = (cur_state == S_RUN) ||
                           ((cur_state == S_DRAIN) && !quiesce_done && !drain_expired);

    assign state = cur_state;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cur_state   <= S_HOLD;
            dut_rst_n   <= 1'b0;
            cycle_count <= 32'd0;
            finish      <= 1'b0;
            timed_out   <= 1'b0;
            hold_cnt    <= 16'd0;
            quiesce_cnt <= 8'd0;
            drain_cnt   <= 32'd0;
        end else begin
            if (cnt_advance) begin
                cycle_count <= cycle_count + 32'd1;
            end
            case (cur_state)
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 16'd1;
                    if (hold_done) begin
                        cur_state <= S_RUN;
                        dut_rst_n <= 1'b1;
                    end
                end
                S_RUN: begin
                    quiesce_cnt <= 8'd0;
                    drain_cnt   <= 32'd0;
                    // The watchdog takes priority so that a coincident finish_req
                    // still records the timeout.
                    if (watchdog_hit) begin
                        cur_state <= S_DRAIN;
                        timed_out <= 1'b1;
                    end else if (finish_req) begin
                        cur_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    drain_cnt   <= drain_cnt + 32'd1;
                    quiesce_cnt <= quiesced ? quiesce_cnt + 8'd1 : 8'd0;
                    // Quiescence beats a timeout that completes on the same cycle.
                    if (quiesce_done) begin
                        cur_state <= S_DONE;
                        finish    <= 1'b1;
                    end else if (drain_expired) begin
                        cur_state <= S_DONE;
                        finish    <= 1'b1;
                        timed_out <= 1'b1;
                    end
                end
                default: begin
                    // DONE is terminal until RST_N is asserted.
                    finish <= 1'b1;
                end
            endcase
        end
    end

`ifdef SIM_HEARTBEAT_EN
    localparam logic [31:0] HB_LAST = 32'(HEARTBEAT_PERIOD - 1);

    logic [31:0] hb_cnt;
    logic [31:0] hb_nxt;

    // hb_cnt tracks cycle_count modulo the period, so the pulse is visible
    // in the same cycle that cycle_count shows PERIOD-1, 2*PERIOD-1, and so on.
    assign hb_nxt = (hb_cnt == HB_LAST) ? 32'd0 : hb_cnt + 32'd1;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hb_cnt    <= 32'd0;
            heartbeat <= 1'b0;
        end else if (cur_state == S_HOLD) begin
            hb_cnt    <= 32'd0;
            // With a period of 1, the first pulse coincides with cycle_count 0.
            heartbeat <= hold_done && (HB_LAST == 32'd0);
        end else if (cnt_advance) begin
            hb_cnt    <= hb_nxt;
            heartbeat <= (hb_nxt == HB_LAST);
        end else begin
            hb_cnt    <= 32'd0;
            heartbeat <= 1'b0;
        end
    end
`else
    assign heartbeat = 1'b0;
`endif

endmodule
